// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory stage of the 16-bit pipeline. Takes the execute-stage bundle and
// produces the register-file writeback. Loads and stores use a request /
// acknowledge handshake to a variable-latency data memory. While an access is
// outstanding, the upstream pipeline is stalled. An access that gets no
// acknowledge within MEM_TIMEOUT cycles is aborted. Non-memory instructions
// reach writeback one cycle after issue.
//
// Parameters:
//   MEM_TIMEOUT  maximum cycles spent in WAIT before the access is aborted (1..255)
//
// Ports:
//   CLK         rising-edge clock
//   RST_N       synchronous active-low reset
//   data_val    store data
//   result      ALU result; writeback data for non-loads; indirect address source
//   addr        direct memory address
//   c_addr      destination register
//   reg_write   instruction writes a register
//   data_read   load
//   data_write  store
//   reg_addr    1: address = result[7:0], 0: address = addr
//   mem_req     memory request, held until ack or timeout
//   mem_we      1 = store
//   mem_addr    memory address
//   mem_wdata   store data
//   mem_rdata   load data, valid together with mem_ack
//   mem_ack     single-cycle acknowledge
//   wb_en       register write strobe (one-cycle pulse)
//   wb_addr     writeback destination register
//   wb_data     writeback data
//   stall       upstream holds its outputs on any edge where stall=1
//   mem_err     one-cycle pulse on timeout or read+write conflict
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] data_val,
    input  logic [15:0] result,
    input  logic [7:0]  addr,
    input  logic [3:0]  c_addr,
    input  logic        reg_write,
    input  logic        data_read,
    input  logic        data_write,
    input  logic        reg_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        stall,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value at which the current WAIT cycle becomes the last one.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [3:0]  c_addr_r;
    logic        reg_write_r;
    logic [15:0] result_r;
    logic        load_r;
    logic        mem_op_s;

    // Any memory operation requested by the instruction in front of the stage.
    always_comb begin
        mem_op_s = data_read | data_write;
    end

    // Upstream stall. This is combinational so upstream can advance on the
    // DONE->IDLE edge. It is forced low while reset is held.
    always_comb begin
        stall = RST_N & (((state_r == ST_IDLE) & mem_op_s) | (state_r == ST_WAIT));
    end

    // Stage FSM with all outputs registered. wb_en and mem_err default low so
    // they only ever pulse for one cycle. The other outputs hold unless updated.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            c_addr_r    <= 4'd0;
            reg_write_r <= 1'b0;
            result_r    <= 16'h0000;
            load_r      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 8'd0;
            mem_wdata   <= 16'h0000;
            wb_en       <= 1'b0;
            wb_addr     <= 4'd0;
            wb_data     <= 16'h0000;
            mem_err     <= 1'b0;
        end else begin
            wb_en   <= 1'b0;
            mem_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s) begin
                        // A read+write conflict is treated as a load. The store is dropped.
                        state_r     <= ST_WAIT;
                        cnt_r       <= 8'd0;
                        mem_req     <= 1'b1;
                        mem_we      <= data_write & ~data_read;
                        mem_addr    <= reg_addr ? result[7:0] : addr;
                        mem_wdata   <= data_val;
                        c_addr_r    <= c_addr;
                        reg_write_r <= reg_write;
                        result_r    <= result;
                        load_r      <= data_read;
                        mem_err     <= data_read & data_write;
                    end else begin
                        wb_en <= reg_write;
                        if (reg_write) begin
                            wb_addr <= c_addr;
                            wb_data <= result;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        state_r <= ST_DONE;
                        mem_req <= 1'b0;
                        wb_en   <= reg_write_r;
                        if (reg_write_r) begin
                            wb_addr <= c_addr_r;
                            wb_data <= load_r ? mem_rdata : result_r;
                        end
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        // Aborted load returns zero. An aborted store still writes back the ALU result.
                        state_r <= ST_DONE;
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        wb_en   <= reg_write_r;
                        if (reg_write_r) begin
                            wb_addr <= c_addr_r;
                            wb_data <= load_r ? 16'h0000 : result_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        CLK;
    logic        RST_N;
    logic [15:0] data_val;
    logic [15:0] result;
    logic [7:0]  addr;
    logic [3:0]  c_addr;
    logic        reg_write;
    logic        data_read;
    logic        data_write;
    logic        reg_addr;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_err;
        logic [3:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];

    mem_access_stage #(.MEM_TIMEOUT(15)) dut (
        .CLK(CLK), .RST_N(RST_N), .data_val(data_val), .result(result),
        .addr(addr), .c_addr(c_addr), .reg_write(reg_write),
        .data_read(data_read), .data_write(data_write), .reg_addr(reg_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .mem_err(mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_wb(input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        e.is_err = 1'b0; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.a = 4'd0; e.d = 16'h0000;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        data_val = 16'h0000; result = 16'h0000; addr = 8'h00; c_addr = 4'h0;
        reg_write = 1'b0; data_read = 1'b0; data_write = 1'b0; reg_addr = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses wb_en or mem_err.
    always @(negedge CLK) begin
        if (wb_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb_en", 32'(wb_en), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_event_kind", 32'(e.is_err), 32'd0);
                chk("wb_addr", 32'(wb_addr), 32'(e.a));
                chk("wb_data", 32'(wb_data), 32'(e.d));
            end
        end
        if (mem_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_mem_err", 32'(mem_err), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("err_event_kind", 32'(e.is_err), 32'd1);
            end
        end
    end

    initial begin
        int n;
        clear_inputs();
        mem_rdata = 16'h0000;
        mem_ack   = 1'b0;
        RST_N     = 1'b0;
        data_read = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_wb_en",     32'(wb_en),     32'd0);
        chk("rst_wb_addr",   32'(wb_addr),   32'd0);
        chk("rst_wb_data",   32'(wb_data),   32'd0);
        chk("rst_mem_err",   32'(mem_err),   32'd0);
        chk("rst_stall",     32'(stall),     32'd0);
        RST_N = 1'b1;
        #1;
        chk("rel_stall", 32'(stall), 32'd1);
        data_read = 1'b0;
        tick();

        // ALU ops back to back
        reg_write = 1'b1; c_addr = 4'h3; result = 16'h1234;
        push_wb(4'h3, 16'h1234);
        #1 chk("alu_stall0", 32'(stall), 32'd0);
        tick();
        c_addr = 4'h5; result = 16'h0055;
        push_wb(4'h5, 16'h0055);
        chk("alu_stall1", 32'(stall), 32'd0);
        tick();
        c_addr = 4'h6; result = 16'hA0A0;
        push_wb(4'h6, 16'hA0A0);
        tick();
        clear_inputs();
        tick();
        tick();

        // Load, indirect address, ack in the 2nd WAIT cycle
        reg_addr = 1'b1; result = 16'h00A5; addr = 8'h33;
        data_read = 1'b1; reg_write = 1'b1; c_addr = 4'h7;
        push_wb(4'h7, 16'hBEEF);
        #1 chk("ld_stall_idle", 32'(stall), 32'd1);
        tick();
        clear_inputs();
        result = 16'h9999;
        #1;
        chk("ld_mem_req",  32'(mem_req),  32'd1);
        chk("ld_mem_we",   32'(mem_we),   32'd0);
        chk("ld_mem_addr", 32'(mem_addr), 32'hA5);
        chk("ld_stall_w1", 32'(stall),    32'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        chk("ld_stall_w2", 32'(stall), 32'd1);
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("ld_stall_done", 32'(stall),   32'd0);
        chk("ld_req_done",   32'(mem_req), 32'd0);
        tick();
        result = 16'h0000;
        tick();

        // Store, immediate ack, spurious acks in DONE and IDLE
        addr = 8'h10; data_val = 16'h55AA; data_write = 1'b1; result = 16'h7777;
        #1 chk("st_stall_idle", 32'(stall), 32'd1);
        tick();
        clear_inputs();
        mem_ack = 1'b1;
        chk("st_mem_req",   32'(mem_req),   32'd1);
        chk("st_mem_we",    32'(mem_we),    32'd1);
        chk("st_mem_addr",  32'(mem_addr),  32'h10);
        chk("st_mem_wdata", 32'(mem_wdata), 32'h55AA);
        chk("st_stall_w",   32'(stall),     32'd1);
        tick();
        chk("st_stall_done", 32'(stall),   32'd0);
        chk("st_req_done",   32'(mem_req), 32'd0);
        tick();
        chk("st_spur_req",   32'(mem_req), 32'd0);
        chk("st_spur_stall", 32'(stall),   32'd0);
        tick();
        mem_ack = 1'b0;
        tick();

        // Store with writeback: data comes from the latched result, not from mem_rdata
        addr = 8'h11; data_val = 16'h0F0F; data_write = 1'b1;
        reg_write = 1'b1; c_addr = 4'hA; result = 16'h4321;
        push_wb(4'hA, 16'h4321);
        tick();
        clear_inputs();
        result = 16'hFFFF;
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000; result = 16'h0000;
        tick();
        tick();

        // Timeout on a load
        addr = 8'h42; data_read = 1'b1; reg_write = 1'b1; c_addr = 4'h9; result = 16'h1111;
        push_wb(4'h9, 16'h0000);
        push_err();
        tick();
        clear_inputs();
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_req_cycles", 32'(n), 32'd15);
        tick();
        tick();

        // Conflict, then reset in the middle of WAIT
        data_read = 1'b1; data_write = 1'b1; reg_write = 1'b1;
        c_addr = 4'h2; addr = 8'h20; data_val = 16'hDEAD;
        push_err();
        tick();
        clear_inputs();
        chk("cf_mem_we",  32'(mem_we),  32'd0);
        chk("cf_mem_req", 32'(mem_req), 32'd1);
        tick();
        RST_N = 1'b0;
        tick();
        chk("rw_mem_req", 32'(mem_req), 32'd0);
        chk("rw_stall",   32'(stall),   32'd0);
        chk("rw_wb_en",   32'(wb_en),   32'd0);
        chk("rw_mem_err", 32'(mem_err), 32'd0);
        RST_N = 1'b1;
        tick();
        tick();
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
